// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end sharing one sequential multiplier between NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog that aborts with resp_err after TIMEOUT cycles.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_accept,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    input  logic [NUM_REQ-1:0]       resp_ack,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_valid_data,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     mul_ack
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner_id;
    logic [PW-1:0] grant_id;
    logic          hit;
    logic          timed_out;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return PW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    // first requesting index at or after rr_ptr, wrapping
    always_comb begin
        hit = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && req_valid[wrap_add(rr_ptr, k)]) begin
                hit = 1'b1;
                grant_id = wrap_add(rr_ptr, k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timed_out = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (Reset || state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            resp_err <= 1'b0;
        else if (state == WAIT)
            resp_err <= timed_out && !mul_done;
        else if (state == RESP && resp_ack[owner_id])
            resp_err <= 1'b0;
    end
`else
    assign timed_out = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner_id       <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            req_accept     <= '0;
            resp_valid     <= '0;
            resp_product   <= '0;
            mul_valid_data <= 1'b0;
            mul_ack        <= 1'b0;
        end else begin
            req_accept     <= '0;
            mul_valid_data <= 1'b0;
            mul_ack        <= 1'b0;
            case (state)
                IDLE: if (hit) begin
                    owner_id   <= grant_id;
                    mul_a      <= req_a[grant_id*WIDTH +: WIDTH];
                    mul_b      <= req_b[grant_id*WIDTH +: WIDTH];
                    req_accept <= NUM_REQ'(1) << grant_id;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    mul_valid_data <= 1'b1;
                    state          <= WAIT;
                end
                WAIT: if (mul_done || timed_out) begin
                    resp_product <= mul_done ? mul_product : '0;
                    resp_valid   <= NUM_REQ'(1) << owner_id;
                    mul_ack      <= 1'b1;
                    state        <= RESP;
                end
                default: if (resp_ack[owner_id]) begin
                    resp_valid <= '0;
                    rr_ptr     <= (owner_id == PW'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table, hand-written corner sequences and randomized traffic for mult_arbiter.
module tb_mult_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] resp_ack = '0;
    logic [N-1:0] req_accept, resp_valid;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [2*W-1:0] resp_product;
    logic [2*W-1:0] mul_product = '0;
    logic resp_err, mul_valid_data, mul_ack;
    logic mul_done = 1'b0;
    logic [W-1:0] mul_a, mul_b;
    int vectors = 0;
    int miscompares = 0;
    int mul_lat = 1;
    int ptr = 0;

    typedef struct {
        logic [N-1:0]   rv;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        int             dly;
        int             owner;
        logic [2*W-1:0] prod;
    } vec_t;
    vec_t tbl [7];

    mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(40)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_accept(req_accept),
        .resp_valid(resp_valid), .resp_product(resp_product), .resp_err(resp_err), .resp_ack(resp_ack),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid_data(mul_valid_data),
        .mul_done(mul_done), .mul_product(mul_product), .mul_ack(mul_ack)
    );

    always #5 Clock = ~Clock;

    // multiplier stand-in: done mul_lat cycles after start, held until mul_ack; mul_lat<=0 never finishes
    initial begin : mul_model
        int cnt;
        logic [W-1:0] pa, pb;
        cnt = -1;
        pa = '0;
        pb = '0;
        forever begin
            @(posedge Clock);
            #1;
            if (Reset || mul_ack) begin
                mul_done = 1'b0;
                cnt = -1;
            end
            if (!Reset && mul_valid_data) begin
                pa = mul_a;
                pb = mul_b;
                cnt = mul_lat > 0 ? mul_lat : -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (cnt == 0) begin
                mul_done = 1'b1;
                mul_product = 64'(pa) * 64'(pb);
                cnt = -1;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_for(input bit acc, input string tag);
        int n;
        for (n = 0; n < 60; n++) begin
            tick();
            if (acc ? |req_accept : |resp_valid) break;
        end
        if (n == 60) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no %s within 60 cycles", tag, acc ? "req_accept" : "resp_valid");
        end
    endtask

    function automatic int pick(input logic [N-1:0] rv, input int p);
        for (int k = 0; k < N; k++)
            if (rv[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic serve(input logic [N-1:0] rv, input logic [N*W-1:0] af, input logic [N*W-1:0] bf,
                         input int lat, input int dly, input int owner, input logic [2*W-1:0] prod,
                         input string tag);
        logic [N-1:0] oh;
        oh = N'(1) << owner;
        mul_lat = lat;
        req_valid = rv;
        req_a = af;
        req_b = bf;
        tick();
        chk({tag, ".accept"}, 192'(req_accept), 192'(oh));
        chk({tag, ".operands"}, {mul_a, mul_b}, {af[owner*W +: W], bf[owner*W +: W]});
        req_valid = rv & ~oh;
        tick();
        chk({tag, ".issue"}, {req_accept, mul_valid_data}, {N'(0), 1'b1});
        wait_for(1'b0, tag);
        chk({tag, ".resp"}, {resp_valid, resp_err, mul_ack}, {oh, 1'b0, 1'b1});
        chk({tag, ".product"}, 192'(resp_product), 192'(prod));
        for (int d = 0; d < dly; d++) begin
            resp_ack = N'($urandom) & ~oh;
            tick();
            chk({tag, ".hold"}, {resp_valid, mul_ack, resp_product}, {oh, 1'b0, prod});
        end
        resp_ack = oh;
        tick();
        resp_ack = '0;
        req_valid = '0;
        chk({tag, ".release"}, 192'(resp_valid), '0);
        ptr = (owner + 1) % N;
    endtask

    initial begin
        tbl[0] = '{4'b0100, 32'd7,          32'd6,          3, 0, 2, 64'd42};
        tbl[1] = '{4'b1111, 32'hFFFFFFFF,   32'hFFFFFFFF,   2, 1, 3, 64'hFFFFFFFE00000001};
        tbl[2] = '{4'b0011, 32'd3,          32'd5,          1, 2, 0, 64'd15};
        tbl[3] = '{4'b0001, 32'd100,        32'd200,        4, 0, 0, 64'd20000};
        tbl[4] = '{4'b1010, 32'd0,          32'd12345,      1, 1, 1, 64'd0};
        tbl[5] = '{4'b1100, 32'd65536,      32'd65536,      2, 0, 2, 64'h1_0000_0000};
        tbl[6] = '{4'b0001, 32'h80000000,   32'd2,          3, 2, 0, 64'h1_0000_0000};

        repeat (2) @(posedge Clock);
        #1;
        chk("reset", {req_accept, resp_valid, resp_err, mul_valid_data, mul_ack, mul_a, mul_b, resp_product}, '0);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++)
            serve(tbl[i].rv, {N{tbl[i].a}}, {N{tbl[i].b}}, tbl[i].lat, tbl[i].dly, tbl[i].owner, tbl[i].prod,
                  $sformatf("vec%0d", i));

        // fairness: everyone requesting continuously from a fresh pointer
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mul_lat = 1;
        req_a = {N{32'd3}};
        req_b = {N{32'd4}};
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            wait_for(1'b1, "fair");
            chk($sformatf("fair.grant%0d", g), 192'(req_accept), 192'(N'(1) << (g % N)));
            wait_for(1'b0, "fair");
            tick();
            resp_ack = N'(1) << (g % N);
            tick();
            resp_ack = '0;
        end
        req_valid = '0;
        tick();

        // foreign ack and a long-delayed owner ack; requester 0 waits meanwhile
        mul_lat = 2;
        req_a = {32'd1234, 96'd0};
        req_b = {32'd1000, 96'd0};
        req_valid = 4'b1000;
        tick();
        chk("fack.accept", 192'(req_accept), 192'(4'b1000));
        req_valid = 4'b0001;
        wait_for(1'b0, "fack");
        chk("fack.resp", {resp_valid, resp_product}, {4'b1000, 64'd1234000});
        mul_lat = 0;
        resp_ack = 4'b0010;
        tick();
        resp_ack = '0;
        chk("fack.foreign", {resp_valid, req_accept, mul_valid_data, resp_product}, {4'b1000, 4'b0, 1'b0, 64'd1234000});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fack.hold", {resp_valid, req_accept, mul_valid_data, resp_product}, {4'b1000, 4'b0, 1'b0, 64'd1234000});
        end
        resp_ack = 4'b1000;
        tick();
        resp_ack = '0;
        chk("fack.release", {resp_valid, req_accept}, {4'b0, 4'b0});
        tick();
        chk("fack.next_grant", 192'(req_accept), 192'(4'b0001));
        req_valid = '0;

        // requester 0 never completes; reset 5 cycles after the start pulse
        tick();
        chk("rst.issue", 192'(mul_valid_data), 192'(1'b1));
        repeat (5) @(posedge Clock);
        #1;
        Reset = 1'b1;
        tick();
        chk("rst.outputs", {req_accept, resp_valid, resp_err, mul_valid_data, mul_ack, mul_a, mul_b, resp_product}, '0);
        Reset = 1'b0;
        ptr = 0;
        serve(4'b1111, {N{32'd5}}, {N{32'd9}}, 3, 1, 0, 64'd45, "post_rst");

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] rv;
            logic [N*W-1:0] af, bf;
            int o;
            rv = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                af[i*W +: W] = $urandom;
                bf[i*W +: W] = $urandom;
            end
            o = pick(rv, ptr);
            serve(rv, af, bf, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), o,
                  64'(af[o*W +: W]) * 64'(bf[o*W +: W]), $sformatf("rand%0d", t));
        end

`ifdef ARB_TIMEOUT_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mul_lat = 0;
        req_a = {N{32'd9}};
        req_b = {N{32'd9}};
        req_valid = 4'b0100;
        tick();
        chk("to.accept", 192'(req_accept), 192'(4'b0100));
        req_valid = '0;
        tick();
        chk("to.issue", 192'(mul_valid_data), 192'(1'b1));
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 39)
                chk("to.early", 192'(resp_valid), '0);
        end
        chk("to.fire", {resp_valid, resp_err, mul_ack, resp_product}, {4'b0100, 1'b1, 1'b1, 64'd0});
        tick();
        chk("to.hold", {resp_valid, resp_err, mul_ack}, {4'b0100, 1'b1, 1'b0});
        resp_ack = 4'b0100;
        tick();
        resp_ack = '0;
        chk("to.release", {resp_valid, resp_err}, {4'b0, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one sequential shift-add multiplier between NUM_REQ requesters. It arbitrates round-robin, latches the winner's operands and sequences the multiplier through its valid_data/ack handshake. It then returns the 2*WIDTH product to the owning requester and holds it until that requester acknowledges. It sits between the client blocks and the multiplier's FSM/datapath pair.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
WIDTH, 32, operand width; product is 2*WIDTH
TIMEOUT, 40, watchdog limit in cycles for the WAIT state (used only with ARB_TIMEOUT_EN)

Ports:
Clock  in  1  single clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until its req_accept bit pulses
req_a  in  NUM_REQ*WIDTH  flattened operand a, slice i belongs to requester i
req_b  in  NUM_REQ*WIDTH  flattened operand b
req_accept  out  NUM_REQ  one-cycle one-hot pulse: operands of that requester captured
resp_valid  out  NUM_REQ  one-hot: result ready for that requester
resp_product  out  2*WIDTH  result, valid while any resp_valid bit is high
resp_err  out  1  result aborted by watchdog; qualified by resp_valid
resp_ack  in  NUM_REQ  requester consumed result
mul_a  out  WIDTH  latched operand a to multiplier
mul_b  out  WIDTH  latched operand b to multiplier
mul_valid_data  out  1  start pulse to multiplier
mul_done  in  1  multiplier result valid
mul_product  in  2*WIDTH  multiplier result
mul_ack  out  1  result-read acknowledge to multiplier

Behaviour:
- All outputs are registered. Reset is synchronous and active-high. On Reset: state=IDLE, rr_ptr=0, every output 0, latched operands 0. A Reset mid-operation drops the transaction with no response, and mul_ack is not asserted.
- States: IDLE, ISSUE, WAIT, RESP, encoded in 2 bits.
- IDLE: if req_valid!=0, select the first set bit searching from rr_ptr upward with wrap-around. Latch req_a/req_b slices into mul_a/mul_b and the winner into owner_id. Next cycle: req_accept[owner_id]=1 for exactly 1 cycle and state=ISSUE. If req_valid==0, stay in IDLE.
- ISSUE: mul_valid_data=1 for exactly 1 cycle, then go to WAIT. mul_a/mul_b stay stable from capture until the return to IDLE.
- WAIT: on mul_done=1, latch mul_product into resp_product and go to RESP. Next cycle: mul_ack=1 for 1 cycle and resp_valid[owner_id]=1.
- RESP: hold resp_valid[owner_id] and resp_product until resp_ack[owner_id]=1. On that edge clear resp_valid, set rr_ptr=(owner_id+1) mod NUM_REQ and go to IDLE.
- Latency: request seen to req_accept is 1 cycle. Earliest re-grant is the cycle after the IDLE return.
- req_valid is ignored outside IDLE, so the accept cycle cannot double-grant.
- mul_done is ignored outside WAIT.
- resp_ack bits of non-owners, or any resp_ack outside RESP, are ignored.
- When all requesters assert simultaneously and continuously, grants follow the order 0,1,2,3,0... The same requester is never granted twice in a row while another requester is waiting.
- NUM_REQ=1: always grants requester 0 and rr_ptr stays at 0.
- Without ARB_TIMEOUT_EN, resp_err is constant 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a cycle counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT without mul_done, the block enters RESP with resp_product=0 and resp_err=1. mul_ack pulses once to force the multiplier back to idle. resp_err clears with resp_valid.
- Not defined: no counter is present; WAIT waits indefinitely; resp_err is tied 0.

Test Plan:
- Single request: req_valid[2]=1, a=7, b=6. Required: req_accept=0100 for 1 cycle, mul_valid_data pulses, then mul_done with product 42. Next cycle: resp_valid=0100, resp_product=42, mul_ack pulses. resp_ack[2] returns the block to IDLE and rr_ptr=3.
- Round-robin fairness: all four req_valid held high, each acked after 1 cycle. Grant order must be 0,1,2,3,0 with no repeat while another requester waits.
- Wide operands: a=b=32'hFFFFFFFF. resp_product must be 64'hFFFFFFFE00000001.
- Delayed and foreign ack: resp_ack[1] pulsed while requester 3 owns the result, then resp_ack[3] held low for 10 cycles. resp_valid[3] and the product stay stable throughout, and there is no state change until resp_ack[3]=1.
- Reset mid-WAIT: Reset asserted 5 cycles after mul_valid_data. Next edge: all outputs 0, state IDLE, rr_ptr=0. A new request afterwards is served normally.
- ARB_TIMEOUT_EN with TIMEOUT=40 and mul_done never asserted. resp_valid must rise 40 WAIT cycles after entry with resp_err=1 and product 0, and mul_ack pulses once.
